cl_serial_seq: RTL and testbench

//  Bit-serial sequencer for the shared 1-bit logic cell (XOR/AND/OR/NOT selected by a 2-bit code).

---
 rtl/cl_serial_seq.sv | 114 +++++++++++
 tb/tb_cl_serial_seq.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/cl_serial_seq.sv
// Bit-serial sequencer driving a shared 1-bit logic cell: one cell operation per clock,
// LSB first, across two WIDTH-bit operands, with a start/busy/done handshake.
module cl_serial_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             cl_a,
    output logic             cl_b,
    output logic [1:0]       cl_s,
    input  logic             cl_out
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] acc;
    logic [1:0]       sop;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] acc_next_c;
    logic             last_c;

    // Accumulator value after this cycle's cell output is shifted in at the MSB
    assign acc_next_c = {cl_out, acc[WIDTH-1:1]};
    assign last_c     = (cnt == CW'(WIDTH - 1));

    // Cell drive is registered: it is preloaded with the bit the next RUN cycle needs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            sa     <= '0;
            sb     <= '0;
            acc    <= '0;
            sop    <= 2'b00;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            zero   <= 1'b1;
            cl_a   <= 1'b0;
            cl_b   <= 1'b0;
            cl_s   <= 2'b00;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= RUN;
                        sa    <= a;
                        sb    <= b;
                        sop   <= op;
                        cnt   <= '0;
                        acc   <= '0;
                        busy  <= 1'b1;
                        cl_a  <= a[0];
                        cl_b  <= b[0];
                        cl_s  <= op;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cl_a  <= 1'b0;
                        cl_b  <= 1'b0;
                        cl_s  <= 2'b00;
                    end
                end
                RUN: begin
                    acc <= acc_next_c;
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    if (last_c) begin
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        result <= acc_next_c;
                        zero   <= ~|acc_next_c;
                        cl_a   <= 1'b0;
                        cl_b   <= 1'b0;
                        cl_s   <= 2'b00;
                    end else begin
                        cnt  <= cnt + CW'(1);
                        cl_a <= sa[1];
                        cl_b <= sb[1];
                        cl_s <= sop;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    cl_a  <= 1'b0;
                    cl_b  <= 1'b0;
                    cl_s  <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cl_serial_seq.sv
// Scoreboard bench for cl_serial_seq (WIDTH=8) with a behavioural model of the 1-bit cell.
module tb_cl_serial_seq;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             cl_a;
    logic             cl_b;
    logic [1:0]       cl_s;
    logic             cl_out;

    int n_checks = 0;
    int n_fail   = 0;
    logic [WIDTH-1:0] exp_q[$];

    cl_serial_seq #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset_n (rst_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .zero    (zero),
        .cl_a    (cl_a),
        .cl_b    (cl_b),
        .cl_s    (cl_s),
        .cl_out  (cl_out)
    );

    // Shared logic cell
    always_comb begin
        case (cl_s)
            2'b00:   cl_out = cl_a ^ cl_b;
            2'b01:   cl_out = cl_a & cl_b;
            2'b10:   cl_out = cl_a | cl_b;
            default: cl_out = ~cl_a;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse is matched against the next expected result
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'(0));
            end else begin
                logic [WIDTH-1:0] e;
                e = exp_q.pop_front();
                check("result", 32'(result), 32'(e));
                check("zero", 32'(zero), 32'(e == '0));
            end
        end
    end

    task automatic wait_done(output int lat, output int busy_cycles);
        lat = 0;
        busy_cycles = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cycles++;
            @(negedge clk);
            lat++;
        end
        if (!done) check("done_timeout", 32'(0), 32'(1));
    endtask

    task automatic run_op(input logic [1:0] o, input logic [WIDTH-1:0] xa,
                          input logic [WIDTH-1:0] xb, input logic [WIDTH-1:0] e);
        int lat;
        int bc;
        @(negedge clk);
        start = 1'b1; op = o; a = xa; b = xb;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bc);
        check("latency", 32'(lat), 32'(WIDTH));
        check("busy_cycles", 32'(bc), 32'(WIDTH));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] bits_a;
        int lat;
        int bc;
        int dones;
        start = 1'b0; op = 2'b00; a = '0; b = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_result", 32'(result), 32'(0));
        check("rst_zero", 32'(zero), 32'(1));
        check("rst_cl", 32'({cl_a, cl_b, cl_s}), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Basic operations
        run_op(2'b00, 8'hA5, 8'h3C, 8'h99);
        run_op(2'b01, 8'hA5, 8'h3C, 8'h24);
        run_op(2'b10, 8'hA5, 8'h3C, 8'hBD);
        run_op(2'b11, 8'hA5, 8'h3C, 8'h5A);
        @(negedge clk);
        check("idle_cl", 32'({cl_a, cl_b, cl_s}), 32'(0));
        check("idle_busy", 32'(busy), 32'(0));

        // Zero result and cell drive order
        bits_a = 8'h5A;
        @(negedge clk);
        start = 1'b1; op = 2'b00; a = 8'h5A; b = 8'h5A;
        exp_q.push_back(8'h00);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (i > 0) @(negedge clk);
            check("cl_a_order", 32'(cl_a), 32'(bits_a[i]));
            check("cl_s_run", 32'(cl_s), 32'(0));
        end
        wait_done(lat, bc);

        // start re-pulsed mid-RUN is ignored
        @(negedge clk);
        start = 1'b1; op = 2'b00; a = 8'hA5; b = 8'h3C;
        exp_q.push_back(8'h99);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; op = 2'b01; a = 8'h00; b = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) dones++;
            @(negedge clk);
        end
        check("single_done", 32'(dones), 32'(1));

        // Back-to-back with start held through DONE
        start = 1'b1; op = 2'b10; a = 8'hA5; b = 8'h3C;
        exp_q.push_back(8'hBD);
        @(negedge clk);
        op = 2'b01; a = 8'hFF; b = 8'h0F;
        wait_done(lat, bc);
        exp_q.push_back(8'h0F);
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy", 32'(busy), 32'(1));
        wait_done(lat, bc);
        check("b2b_gap", 32'(lat + 1), 32'(WIDTH + 1));

        // Reset in RUN cycle 4 aborts the operation
        @(negedge clk);
        start = 1'b1; op = 2'b00; a = 8'hA5; b = 8'h3C;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_done", 32'(done), 32'(0));
        check("abort_result", 32'(result), 32'(0));
        check("abort_zero", 32'(zero), 32'(1));
        check("abort_cl", 32'({cl_a, cl_b, cl_s}), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("abort_no_done", 32'(dones), 32'(0));
        run_op(2'b11, 8'h3C, 8'h00, 8'hC3);

        repeat (3) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
